// File: rtl/example_1_sweep_ctrl.sv
// Self-test sequencer for the example_1 block: sweeps all 2**N_IN input vectors and scores the responses.
// Latency: 1 + 2**N_IN*(SETTLE+1) cycles from start acceptance to the done pulse.
// Backpressure: none; start is only sampled in IDLE. SWEEP_CAPTURE_EN adds the observed-table capture port.
module example_1_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         dut_in,
    input  logic [N_OUT-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic                    fail_valid,
    output logic [N_IN-1:0]         first_fail_idx
`ifdef SWEEP_CAPTURE_EN
    ,
    output logic [(2**N_IN)*N_OUT-1:0] capture
`endif
);

    localparam int              TBL_W       = (2**N_IN)*N_OUT;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx, idx_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
    logic [N_IN:0]   err_count_nxt;
    logic [N_IN-1:0] first_fail_idx_nxt;
    logic [N_OUT-1:0] exp_slice;
    logic            mismatch;
`ifdef SWEEP_CAPTURE_EN
    logic [TBL_W-1:0] capture_nxt;
`endif

    // The vector index is the stimulus; it is held in a flop so dut_in is registered.
    assign dut_in = idx;

    // Expected response for the vector currently applied, and its comparison.
    always_comb begin
        exp_slice = EXP_TABLE[int'(idx)*N_OUT +: N_OUT];
        mismatch  = (dut_out != exp_slice);
    end

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        cnt_nxt            = cnt;
        busy_nxt           = busy;
        done_nxt           = 1'b0;
        pass_nxt           = pass;
        err_count_nxt      = err_count;
        fail_valid_nxt     = fail_valid;
        first_fail_idx_nxt = first_fail_idx;
`ifdef SWEEP_CAPTURE_EN
        capture_nxt        = capture;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt          = S_SETTLE;
                    idx_nxt            = '0;
                    cnt_nxt            = '0;
                    busy_nxt           = 1'b1;
                    pass_nxt           = 1'b0;
                    err_count_nxt      = '0;
                    fail_valid_nxt     = 1'b0;
                    first_fail_idx_nxt = '0;
`ifdef SWEEP_CAPTURE_EN
                    capture_nxt        = '0;
`endif
                end
            end
            S_SETTLE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_count_nxt = err_count + (N_IN+1)'(1);
                    if (!fail_valid) begin
                        fail_valid_nxt     = 1'b1;
                        first_fail_idx_nxt = idx;
                    end
                end
`ifdef SWEEP_CAPTURE_EN
                capture_nxt[int'(idx)*N_OUT +: N_OUT] = dut_out;
`endif
                if (idx == IDX_LAST) begin
                    // pass is computed from the count including this last sample.
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count_nxt == '0);
                end else begin
                    state_nxt = S_SETTLE;
                    idx_nxt   = idx + N_IN'(1);
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
`ifdef SWEEP_CAPTURE_EN
            capture        <= '0;
`endif
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            cnt            <= cnt_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_count_nxt;
            fail_valid     <= fail_valid_nxt;
            first_fail_idx <= first_fail_idx_nxt;
`ifdef SWEEP_CAPTURE_EN
            capture        <= capture_nxt;
`endif
        end
    end

endmodule
